cpu_mc_param: RTL and testbench

//  Parametrised multicycle (5-stage, non-pipelined) load/store CPU; next generation of the team's 10-bit CPU.

---
 rtl/cpu_mc_param.sv | 157 +++++++++++++++
 tb/tb_cpu_mc_param.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc_param.sv
// Parametrised multicycle load/store CPU: FETCH/OPA/OPB/EXEC/WB per instruction,
// with run/halt control, program-load port, data-memory debug read and sticky illegal flag.
module cpu_mc_param #(
    parameter int DATA_W     = 10,
    parameter int RF_DEPTH   = 16,
    parameter int MEM_DEPTH  = 32,
    parameter int IMEM_DEPTH = 32,
    localparam int RA_W  = $clog2(RF_DEPTH),
    localparam int MA_W  = $clog2(MEM_DEPTH),
    localparam int PC_W  = $clog2(IMEM_DEPTH),
    localparam int FLD_W = (RA_W > MA_W) ? ((RA_W > PC_W) ? RA_W : PC_W)
                                         : ((MA_W > PC_W) ? MA_W : PC_W),
    localparam int CMD_W = 4 + FLD_W + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [CMD_W-1:0]  prog_data,
    input  logic [MA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int F1_LSB = CMD_W - 4 - FLD_W;
    localparam int F2_LSB = F1_LSB - FLD_W;
    localparam int F3_LSB = F2_LSB - FLD_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_OPA, S_OPB, S_EXEC, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,  OP_LTM = 4'd1,  OP_MTR = 4'd2,  OP_RTR = 4'd3,
        OP_JL  = 4'd4,  OP_SUB = 4'd5,  OP_SUM = 4'd6,  OP_MTRK = 4'd7,
        OP_RTM = 4'd8,  OP_JMP = 4'd9,  OP_JZ  = 4'd10, OP_AND = 4'd11,
        OP_XOR = 4'd12, OP_SHR = 4'd13, OP_ILL = 4'd14, OP_HLT = 4'd15
    } op_t;

    state_t state, state_nx;

    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op_a, op_b, op_m, result;
    logic              taken;
    logic [DATA_W-1:0] rf   [RF_DEPTH];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic [CMD_W-1:0]  imem [IMEM_DEPTH];

    op_t               cop;
    logic [RA_W-1:0]   f1_ra, f2_ra, f3_ra;
    logic [MA_W-1:0]   f1_ma;
    logic [DATA_W-1:0] lit;
    logic [PC_W-1:0]   tgt, pc_inc;
    logic              ctrl_idle;

    assign cop    = op_t'(cmd[CMD_W-1 -: 4]);
    assign f1_ra  = cmd[F1_LSB +: RA_W];
    assign f1_ma  = cmd[F1_LSB +: MA_W];
    assign f2_ra  = cmd[F2_LSB +: RA_W];
    assign f3_ra  = cmd[F3_LSB +: RA_W];
    assign lit    = cmd[DATA_W-1:0];
    assign tgt    = cmd[PC_W-1:0];
    assign pc_inc = (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);

    assign ctrl_idle = (state == S_IDLE) || (state == S_HALT);
    assign busy      = !ctrl_idle;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
            S_FETCH:        state_nx = S_OPA;
            S_OPA:          state_nx = S_OPB;
            S_OPB:          state_nx = S_EXEC;
            S_EXEC:         state_nx = S_WB;
            S_WB:           state_nx = (cop == OP_HLT) ? S_HALT : S_FETCH;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            cmd      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_m     <= '0;
            result   <= '0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
            dbg_data <= '0;
            for (int unsigned i = 0; i < RF_DEPTH; i++)
                rf[i] <= (i == 1) ? DATA_W'(1) : '0;
        end else begin
            dbg_data <= mem[dbg_addr];
            case (state)
                S_IDLE, S_HALT: if (start) begin
                    pc      <= '0;
                    illegal <= 1'b0;
                end
                S_FETCH: cmd  <= imem[pc];
                S_OPA:   op_a <= rf[f1_ra];
                S_OPB: begin
                    op_b <= rf[f2_ra];
                    // direct (MTR) or register-indirect (MTRK) memory operand
                    op_m <= mem[(cop == OP_MTRK) ? op_a[MA_W-1:0] : f1_ma];
                end
                S_EXEC: begin
                    case (cop)
                        OP_MTR, OP_MTRK: result <= op_m;
                        OP_RTR:          result <= op_b;
                        OP_SUB:          result <= op_a - op_b;
                        OP_SUM:          result <= op_a + op_b;
                        OP_AND:          result <= op_a & op_b;
                        OP_XOR:          result <= op_a ^ op_b;
                        OP_SHR:          result <= op_a >> 1;
                        default:         result <= '0;
                    endcase
                    taken <= (cop == OP_JMP)
                          || ((cop == OP_JL) && (op_a < op_b))
                          || ((cop == OP_JZ) && (op_a == '0));
                end
                S_WB: begin
                    case (cop)
                        OP_MTR, OP_MTRK: rf[f2_ra] <= result;
                        OP_RTR:          rf[f1_ra] <= result;
                        OP_SUB, OP_SUM, OP_AND, OP_XOR, OP_SHR:
                                         rf[f3_ra] <= result;
                        OP_ILL:          illegal   <= 1'b1;
                        default: ;
                    endcase
                    if (cop != OP_HLT)
                        pc <= taken ? tgt : pc_inc;
                end
                default: ;
            endcase
        end
    end

    // memories are not reset; async reset forces IDLE so an aborted WB never writes
    always_ff @(posedge clk) begin
        if (state == S_WB && cop == OP_LTM) mem[f1_ma] <= lit;
        if (state == S_WB && cop == OP_RTM) mem[op_a[MA_W-1:0]] <= op_b;
        if (prog_we && ctrl_idle) imem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_cpu_mc_param.sv
// Scoreboard bench for cpu_mc_param: an instruction-level interpreter predicts
// halt pc, illegal flag, busy cycles and data-memory contents read via the debug port.
module tb_cpu_mc_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [18:0] prog_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [9:0]  dbg_data;
    logic [4:0]  pc;
    logic        busy, halted, illegal;

    cpu_mc_param #(.DATA_W(10), .RF_DEPTH(16), .MEM_DEPTH(32), .IMEM_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int          rf_m [16];
    int          mem_m [32];
    logic [18:0] imem_m [32];

    typedef struct { int pc; int ill; int cyc; } exp_t;
    exp_t exp_q [$];
    int   dbg_q [$];

    bit dbg_req = 0, dbg_pend = 0, halted_q = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] enc(input int op, input int f1, input int f2, input int f3);
        return {op[3:0], f1[4:0], f2[4:0], f3[4:0]};
    endfunction

    function automatic logic [18:0] enc_lit(input int op, input int f1, input int lit);
        return {op[3:0], f1[4:0], lit[9:0]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic summary_and_quit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Instruction-level interpreter; one iteration per architectural instruction.
    task automatic model_run();
        int pcm = 0, n = 0, ill = 0;
        int op, f1, f2, f3, a, b, npc;
        logic [18:0] w;
        forever begin
            w  = imem_m[pcm];
            op = int'(w[18:15]); f1 = int'(w[14:10]); f2 = int'(w[9:5]); f3 = int'(w[4:0]);
            a  = rf_m[f1 % 16];
            b  = rf_m[f2 % 16];
            npc = (pcm + 1) % 32;
            n++;
            if (op == 15) break;
            case (op)
                1:  mem_m[f1] = int'(w[9:0]);
                2:  rf_m[f2 % 16] = mem_m[f1];
                3:  rf_m[f1 % 16] = b;
                4:  if (a < b) npc = f3;
                5:  rf_m[f3 % 16] = (a - b + 1024) % 1024;
                6:  rf_m[f3 % 16] = (a + b) % 1024;
                7:  rf_m[f2 % 16] = mem_m[a % 32];
                8:  mem_m[a % 32] = b;
                9:  npc = f3;
                10: if (a == 0) npc = f3;
                11: rf_m[f3 % 16] = a & b;
                12: rf_m[f3 % 16] = a ^ b;
                13: rf_m[f3 % 16] = a / 2;
                14: ill = 1;
                default: ;
            endcase
            pcm = npc;
            if (n > 600) begin
                $display("FAIL model: program does not halt");
                miscompares++;
                summary_and_quit();
            end
        end
        exp_q.push_back('{pc: pcm, ill: ill, cyc: 5 * n});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rf_m[i] = (i == 1) ? 1 : 0;
    endtask

    task automatic load_word(input int a, input logic [18:0] w);
        prog_we = 1'b1; prog_addr = a[4:0]; prog_data = w;
        imem_m[a] = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 3000; i++) begin
            if (halted) return;
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL halt_timeout: got halted=0, expected halted=1");
        summary_and_quit();
    endtask

    task automatic run();
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halt();
    endtask

    task automatic dbg_rd(input int a);
        dbg_addr = a[4:0];
        dbg_req  = 1'b1;
        dbg_q.push_back(mem_m[a]);
        tick();
        dbg_req  = 1'b0;
    endtask

    task automatic dbg_sweep();
        for (int a = 0; a < 32; a++) dbg_rd(a);
    endtask

    // Monitor: scores each halt against the queued prediction and each debug read one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (reset) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (halted && !halted_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_halt", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("halt_pc", 32'(pc), e.pc);
                check("halt_illegal", 32'(illegal), e.ill);
                check("busy_cycles", 32'(busy_cnt), e.cyc);
            end
            busy_cnt = 0;
        end
        halted_q = halted;
        if (dbg_pend) check("dbg_data", 32'(dbg_data), dbg_q.pop_front());
        dbg_pend = dbg_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 0;
        tick(); tick();
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_dbg_data", 32'(dbg_data), 0);
        reset = 1'b0;
        tick();

        // LTM then HLT, last word loaded in the same cycle as start
        load_word(0, enc_lit(1, 3, 'h155));
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = enc(15, 0, 0, 0);
        imem_m[1] = enc(15, 0, 0, 0);
        start = 1'b1;
        model_run();
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_halt();
        dbg_rd(3);

        // clear all of data memory so later sweeps are fully predictable
        for (int i = 0; i < 31; i++) load_word(i, enc_lit(1, i, 0));
        load_word(31, enc(15, 0, 0, 0));
        run();
        load_word(0, enc_lit(1, 31, 0));
        load_word(1, enc(15, 0, 0, 0));
        run();
        dbg_sweep();

        // counted loop: r2 += r1+r1, four iterations
        load_word(0, enc_lit(1, 0, 4));
        load_word(1, enc(2, 0, 3, 0));
        load_word(2, enc(6, 1, 1, 4));
        load_word(3, enc(6, 2, 4, 2));
        load_word(4, enc(5, 3, 1, 3));
        load_word(5, enc(10, 3, 0, 7));
        load_word(6, enc(9, 0, 0, 2));
        load_word(7, enc(8, 0, 2, 0));
        load_word(8, enc(15, 0, 0, 0));
        run();
        dbg_rd(0);

        // wrap-around arithmetic, SHR, JL taken / not taken
        load_word(0, enc_lit(1, 1, 'h3FF));
        load_word(1, enc(2, 1, 5, 0));
        load_word(2, enc(6, 5, 1, 6));
        load_word(3, enc(5, 0, 1, 7));
        load_word(4, enc(13, 5, 0, 8));
        load_word(5, enc(6, 1, 1, 9));
        load_word(6, enc(8, 0, 6, 0));
        load_word(7, enc(8, 1, 7, 0));
        load_word(8, enc(8, 9, 8, 0));
        load_word(9, enc(4, 1, 5, 11));
        load_word(10, enc_lit(1, 3, 'h111));
        load_word(11, enc(4, 5, 1, 13));
        load_word(12, enc_lit(1, 4, 'h222));
        load_word(13, enc(15, 0, 0, 0));
        run();
        for (int a = 0; a < 5; a++) dbg_rd(a);

        // JZ to 30, fall through 31, pc wraps to 0, JZ then not taken
        load_word(0, enc(10, 11, 0, 30));
        load_word(1, enc(8, 1, 11, 0));
        load_word(2, enc(15, 0, 0, 0));
        load_word(30, enc(6, 1, 1, 11));
        load_word(31, enc(0, 0, 0, 0));
        run();
        dbg_rd(1);

        // opcode 14 sets the sticky flag and otherwise acts as NOP
        load_word(0, enc(14, 3, 4, 5));
        load_word(1, enc_lit(1, 1, 'h2AA));
        load_word(2, enc(15, 0, 0, 0));
        run();
        dbg_rd(1);

        // reset during EXEC of RTM at pc=1; prog_we while busy is dropped
        load_word(0, enc(0, 0, 0, 0));
        load_word(1, enc(8, 1, 0, 0));
        load_word(2, enc(9, 0, 0, 5));
        load_word(5, enc_lit(1, 7, 'h123));
        load_word(6, enc(15, 0, 0, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_illegal", 32'(illegal), 0);
        prog_we = 1'b1; prog_addr = 5'd5; prog_data = enc_lit(1, 7, 'h3C3);
        tick();
        prog_we = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pc_before_abort", 32'(pc), 1);
        reset = 1'b1;
        #1;
        check("async_rst_pc", 32'(pc), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_halted", 32'(halted), 0);
        check("async_rst_dbg_data", 32'(dbg_data), 0);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        dbg_rd(1);
        run();
        dbg_rd(1);
        dbg_rd(7);

        // random forward-jumping programs ending in HLT
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(20, 6);
            for (int i = 0; i < len; i++) begin
                int op;
                logic [18:0] w;
                op = $urandom_range(14, 0);
                w  = {op[3:0], 15'($urandom)};
                if (op == 4 || op == 9 || op == 10) begin
                    int t;
                    t = $urandom_range(len, i + 1);
                    w[4:0] = t[4:0];
                end
                load_word(i, w);
            end
            load_word(len, enc(15, 0, 0, 0));
            run();
            dbg_sweep();
        end

        tick(); tick();
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("dbg_q_drained", 32'(dbg_q.size()), 0);
        summary_and_quit();
    end

endmodule
